uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART receiver. It captures each byte presented with a one-cycle `rdata_vld` strobe and stores it in a first-word-fall-through FIFO. The FIFO presents bytes to the consumer over a valid/ready interface. It reports fill level, almost-full (usable as RTS-style flow control) and a sticky overflow flag for dropped bytes.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2, >= 2
- AFULL_THRESH, 12, `level` at or above which `almost_full` asserts; range 1..DEPTH

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rdata_vld  input  1  one-cycle strobe from the UART receiver: `rdata` is a new byte
- rdata  input  8  received byte, sampled when `rdata_vld`=1
- m_data  output  8  head-of-FIFO byte, valid when `m_valid`=1
- m_valid  output  1  FIFO non-empty
- m_ready  input  1  consumer accepts `m_data` this cycle when `m_valid`=1
- level  output  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH
- almost_full  output  1  `level` >= AFULL_THRESH
- overflow  output  1  sticky: at least one byte was dropped because the FIFO was full
- ovf_clr  input  1  synchronous clear of `overflow`

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While `rst` is high: read/write pointers = 0, `level` = 0, `m_valid` = 0, `almost_full` = 0, `overflow` = 0.
  - `m_data` is don't-care while `m_valid` = 0; the bench must not check it.
  - Storage array contents are not reset.
  - Reset asserted mid-operation discards all stored bytes immediately, without waiting for a clock edge.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide (extra wrap bit).
  - Empty = pointers equal. Full = low bits equal and wrap bits differ.
  - Pointers wrap modulo 2*DEPTH with no special handling.
- Push: `rdata_vld`=1 and (not full, or a pop occurs in the same cycle) -> `rdata` is written at the write pointer and the write pointer increments.
- Pop: `m_valid`=1 and `m_ready`=1 -> the read pointer increments. `m_ready` while empty has no effect.
- Registered status:
  - `level`, `m_valid` and `almost_full` are registered and reflect the post-edge occupancy.
  - `level` increments on push-only, decrements on pop-only, and is unchanged on push+pop or when idle.
- Latency (fall-through):
  - A byte pushed into an empty FIFO on edge N gives `m_valid`=1 and `m_data`=byte after edge N, i.e. one cycle after the `rdata_vld` strobe.
  - `m_data` = mem[read pointer], read combinationally from the register array.
  - `m_data` holds stable while `m_valid`=1 and `m_ready`=0.
- Simultaneous push+pop:
  - When empty: only the push takes effect (`m_valid` was 0, so no pop).
  - When full: the pop frees the slot, the push is accepted, `level` stays DEPTH, and there is no overflow.
- Overflow:
  - `rdata_vld`=1 while full with no same-cycle pop -> the byte is dropped, pointers and `level` are unchanged, and `overflow` is set on the next edge.
  - `overflow` stays set until `ovf_clr`=1.
  - If `ovf_clr` and a new drop occur in the same cycle, set wins and `overflow` = 1.
- `almost_full`: a registered compare of the next-state level against AFULL_THRESH. It updates on the same edge as `level`.
- Input assumptions: `rdata_vld` is a single-cycle pulse with no back-pressure to the receiver, so the FIFO must accept one byte per cycle sustained.

Test Plan:
- Push and drain: from reset, strobe 0x55, 0xA3, 0x0F on non-consecutive cycles with `m_ready`=0.
  - Required: `m_valid` rises one cycle after the first strobe, `m_data`=0x55, `level`=3.
  - Then hold `m_ready`=1: 0x55, 0xA3, 0x0F pop on consecutive cycles, `level` reaches 0, `m_valid`=0.
- Fill and overflow: DEPTH=16, push 0x00..0x0F with `m_ready`=0.
  - Required: `level`=16 and `almost_full`=1 (first asserts when `level` reaches 12).
  - Push 0xEE: dropped, `overflow`=1, `level`=16.
  - Drain 16 bytes: 0x00..0x0F in order, with 0xEE absent.
- Push+pop at full: while full, assert `rdata_vld` (0x77) and `m_ready` in the same cycle.
  - Required: head 0x00 consumed, `level` stays 16, `overflow` stays 0, and 0x77 emerges last on drain.
- Overflow clear precedence: while full, assert `ovf_clr` in the same cycle as a dropped push -> `overflow`=1.
  - Next cycle, `ovf_clr` alone -> `overflow`=0.
- Wrap-around: stream 40 bytes (0x00..0x27), one every 3 cycles, with `m_ready`=1 continuously.
  - Required: all 40 bytes out in order, `level` never exceeds 1, and the pointers have wrapped twice.
- Async reset mid-stream: with `level`=5, pulse `rst` between clock edges.
  - Required: `m_valid`, `level`, `almost_full` and `overflow` go to 0 immediately.
  - Next push 0x3C emerges as the first byte.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the byte-ingress strobe, the consumer valid/ready stream and the
// status/flow-control signals of the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          rdata_vld;
  logic [7:0]    rdata;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          ovf_clr;

  // master = environment (UART receiver + consumer), slave = the FIFO itself
  modport master (
    output rdata_vld, rdata, m_ready, ovf_clr,
    input  m_data, m_valid, level, almost_full, overflow
  );

  modport slave (
    input  rdata_vld, rdata, m_ready, ovf_clr,
    output m_data, m_valid, level, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind a UART receiver, with registered
// fill level, almost-full flow control and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  // Handshake: a byte leaves the FIFO on a clock edge where m_valid and
  // m_ready are both 1; m_data is stable while m_valid=1 and m_ready=0.
  // The ingress side has no back-pressure: rdata_vld is a one-cycle strobe
  // and a byte arriving while full (with no same-cycle pop) is dropped.

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                (wr_ptr_q[AW]     != rd_ptr_q[AW]);
  assign pop  = valid_q && bus.m_ready;
  // A pop in the same cycle frees the head slot, so a push at full is legal.
  assign push = bus.rdata_vld && (!full || pop);
  assign drop = bus.rdata_vld && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push && !pop)      level_d = level_q + PTR_ONE;
    else if (pop && !push) level_d = level_q - PTR_ONE;

    // A fresh drop outranks a clear in the same cycle.
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;

    valid_d = (level_d != '0);
    afull_d = (level_d >= AFULL_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.rdata;
  end

  assign bus.m_data      = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.m_valid     = valid_q;
  assign bus.level       = level_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: push/drain, fill/overflow, push+pop at
// full, overflow clear precedence, pointer wrap and asynchronous reset.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_tests;
  int         n_fail;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe one byte; 'accept' says whether the bench expects it stored.
  task automatic push_byte(input logic [7:0] b, input bit accept);
    bus.rdata_vld = 1'b1;
    bus.rdata     = b;
    tick();
    bus.rdata_vld = 1'b0;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_valid"}, 32'(bus.m_valid), 1);
    check({tag, "_data"},  32'(bus.m_data),  32'(e));
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid0"}, 32'(bus.m_valid), 0);
    check({tag, "_level0"}, 32'(bus.level),   0);
  endtask

  // ---------------- stimulus ----------------
  int max_level;

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.rdata_vld = 1'b0;
    bus.rdata     = 8'h00;
    bus.m_ready   = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Reset state
    idle(2);
    check("rst_valid", 32'(bus.m_valid),     0);
    check("rst_level", 32'(bus.level),       0);
    check("rst_afull", 32'(bus.almost_full), 0);
    check("rst_ovf",   32'(bus.overflow),    0);
    rst = 1'b0;
    idle(1);

    // 1. Push and drain
    push_byte(8'h55, 1);
    check("t1_valid_lat", 32'(bus.m_valid), 1);
    check("t1_head",      32'(bus.m_data),  32'h55);
    idle(1);
    push_byte(8'hA3, 1);
    idle(2);
    push_byte(8'h0F, 1);
    check("t1_level3", 32'(bus.level),  3);
    check("t1_hold",   32'(bus.m_data), 32'h55);
    bus.m_ready = 1'b1;
    check("t1_pop0", 32'(bus.m_data), 32'(exp_q.pop_front()));
    tick();
    check("t1_pop1", 32'(bus.m_data), 32'(exp_q.pop_front()));
    tick();
    check("t1_pop2", 32'(bus.m_data), 32'(exp_q.pop_front()));
    tick();
    bus.m_ready = 1'b0;
    check_empty("t1_end");

    // 2. Fill and overflow
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'(i), 1);
      check($sformatf("t2_afull_%0d", i + 1), 32'(bus.almost_full), (i + 1 >= THR) ? 1 : 0);
    end
    check("t2_level16", 32'(bus.level),    16);
    check("t2_ovf0",    32'(bus.overflow), 0);
    push_byte(8'hEE, 0);
    check("t2_ovf1",       32'(bus.overflow), 1);
    check("t2_level_drop", 32'(bus.level),    16);
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("t2_drain%0d", i));
    check_empty("t2_end");
    check("t2_ovf_sticky", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t2_ovf_clr", 32'(bus.overflow), 0);

    // 3. Push+pop at full
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1);
    check("t3_full", 32'(bus.level), 16);
    check("t3_head", 32'(bus.m_data), 32'(exp_q.pop_front()));
    bus.m_ready = 1'b1;
    push_byte(8'h77, 1);
    bus.m_ready = 1'b0;
    check("t3_level", 32'(bus.level),    16);
    check("t3_ovf",   32'(bus.overflow), 0);
    check("t3_next",  32'(bus.m_data),   32'h01);

    // 4. Overflow clear precedence (still full)
    bus.ovf_clr = 1'b1;
    push_byte(8'hEE, 0);
    bus.ovf_clr = 1'b0;
    check("t4_set_wins", 32'(bus.overflow), 1);
    check("t4_level",    32'(bus.level),    16);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("t4_clear", 32'(bus.overflow), 0);
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("t3_drain%0d", i));
    check_empty("t3_end");

    // 5. Wrap-around streaming with m_ready held high
    max_level   = 0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i), 1);
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
      check($sformatf("t5_valid%0d", i), 32'(bus.m_valid), 1);
      check($sformatf("t5_data%0d", i),  32'(bus.m_data),  32'(exp_q.pop_front()));
      for (int k = 0; k < 2; k++) begin
        tick();
        if (int'(bus.level) > max_level) max_level = int'(bus.level);
      end
    end
    bus.m_ready = 1'b0;
    check("t5_max_level", 32'(max_level), 1);
    check_empty("t5_end");

    // 6. Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 1);
    check("t6_level5", 32'(bus.level), 5);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.m_valid),     0);
    check("t6_async_level", 32'(bus.level),       0);
    check("t6_async_afull", 32'(bus.almost_full), 0);
    check("t6_async_ovf",   32'(bus.overflow),    0);
    rst = 1'b0;
    exp_q.delete();
    idle(1);
    push_byte(8'h3C, 1);
    check("t6_level1", 32'(bus.level), 1);
    pop_one("t6_first");
    check_empty("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
